// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, select width, merge-stage FSM states
// and the wrap-around port index increment.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 6;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Port index after idx, wrapping from the last port back to 0
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_PORTS - 1)) ? '0 : idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb6.sv
// Six-way round-robin priority scan: first requester at or after ptr, wrapping at 6.
module rr_arb6
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic                 gnt_valid,
  output logic [SEL_W-1:0]     gnt_idx
);

  logic [SEL_W-1:0] w_idx;

  // An out-of-range pointer is treated as 0 so the scan never indexes past req
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = (ptr < SEL_W'(NUM_PORTS)) ? ptr : '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
      w_idx = next_idx(w_idx);
    end
  end

endmodule

// File: rtl/mux6to1_rr.sv
// Six-input round-robin flit merge stage with per-packet grant lock and a
// registered valid/ready output channel.
module mux6to1_rr
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_tail,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic                        out_tail,
  output logic [DATA_W-1:0]           out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  state_e             r_state;
  logic [SEL_W-1:0]   r_lock_idx;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic               r_out_tail;
  logic [DATA_W-1:0]  r_out_data;
  logic [SEL_W-1:0]   r_out_sel;

  logic               w_arb_valid;
  logic [SEL_W-1:0]   w_arb_idx;
  logic               w_gnt_valid;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic               w_can_load;
  logic               w_in_fire;
  logic               w_in_tail;
  logic [DATA_W-1:0]  w_in_data;

  rr_arb6 u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_arb_valid),
    .gnt_idx   (w_arb_idx)
  );

  // While locked the grant stays on the packet owner even if it stalls
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_gnt_valid = (r_state == LOCKED) || w_arb_valid;
  assign w_gnt_idx   = (r_state == LOCKED) ? r_lock_idx : w_arb_idx;

  // Steer the granted input and raise its ready in the same cycle
  always_comb begin
    w_in_data = '0;
    w_in_tail = 1'b0;
    w_in_fire = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_in_data   = in_data[i*DATA_W +: DATA_W];
        w_in_tail   = in_tail[i];
        w_in_fire   = w_can_load && w_gnt_valid && in_valid[i];
        in_ready[i] = w_in_fire;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lock_idx  <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else begin
      if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_tail  <= w_in_tail;
        r_out_data  <= w_in_data;
        r_out_sel   <= w_gnt_idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // The pointer only advances on an arbitrated (head or single) flit
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_rr_ptr <= next_idx(w_gnt_idx);
            if (!w_in_tail) begin
              r_lock_idx <= w_gnt_idx;
              r_state    <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (w_in_fire && w_in_tail) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_tail  = r_out_tail;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: doc/mux6to1_rr.md
# mux6to1_rr

Six-input to one-output flit merge stage for the NoC router output side: the counterpart of the router's 1-to-6 steering demux. It arbitrates among six upstream flit channels using round-robin priority and holds a grant for the whole packet (head through tail). It drives one registered output channel with a valid/ready handshake. Its select encoding matches the demux encoding: 000 = in1 … 101 = in6.

## Interface

Parameters:
- DATA_W, 64, flit payload width in bits.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  6  per-input flit valid; bit i = input i+1.
- in_tail  input  6  per-input tail marker for the flit presented. A single-flit packet has tail = 1.
- in_data  input  6*DATA_W  per-input payload; slice i = in_data[i*DATA_W +: DATA_W].
- in_ready  output  6  per-input accept; at most one bit high in any cycle.
- out_valid  output  1  output register holds a flit.
- out_tail  output  1  tail marker of the held flit.
- out_data  output  DATA_W  held payload.
- out_sel  output  3  source index of the held flit (000–101).
- out_ready  input  1  downstream accept.

## Operation

- Transfer in: input i transfers when in_valid[i] && in_ready[i].
- Transfer out: the output transfers when out_valid && out_ready.
- can_load = !out_valid || out_ready.
  - in_ready[i] = can_load && (grant == i) && in_valid[i].
  - in_ready is computed combinationally in the same cycle; there is no bubble.
- FSM has two states, IDLE and LOCKED.
  - IDLE:
    - The winner is the first input with in_valid set, scanning from rr_ptr upward and wrapping at 6.
    - When the winner transfers, rr_ptr ← (winner+1) mod 6.
    - If that flit's in_tail = 0: lock_idx ← winner and go to LOCKED. If in_tail = 1, stay in IDLE.
  - LOCKED:
    - grant = lock_idx regardless of other valids. Other inputs see in_ready = 0.
    - When the locked input transfers a flit with in_tail = 1, go to IDLE.
    - rr_ptr does not change while in LOCKED.
- On any input transfer, the output register loads {data, tail, sel = granted index} and out_valid ← 1.
- If the output transfers and no input transfers in the same cycle, out_valid ← 0. data, tail and sel keep their values.
- No valids in IDLE: no grant, all in_ready = 0, and the state is unchanged.
- A locked input dropping in_valid mid-packet: the lock is held and the block waits. This is legal and no error is raised.
- rr_ptr wraps 5 → 0.

## Timing

- Reset values: out_valid = 0, out_tail = 0, out_data = 0, out_sel = 000, in_ready = 0 (combinational, since out_valid = 0 but no grant exists), rr_ptr = 0, state = IDLE, lock_idx = 0.
- Reset is asynchronous. Asserting reset mid-packet abandons the lock immediately and returns to IDLE with rr_ptr = 0. Upstream is responsible for flushing.
- Latency: a flit accepted at edge N is visible on out_* after edge N and remains until the downstream transfer.
- Throughput: 1 flit/cycle while out_ready = 1.
  - Arbitration does not cost a cycle: a new packet can be granted in the cycle immediately after the previous tail transfers.
- Back-pressure: out_valid && !out_ready → can_load = 0.
  - All in_ready = 0 and the output is held stable (data, tail and sel unchanged).
- Simultaneous output drain and input load in the same cycle: out_valid stays 1 and the register takes the new flit.

## Structure

- Shared package noc_pkg:
  - NUM_PORTS = 6, SEL_W = 3.
  - FSM state enum {IDLE, LOCKED}.
  - Function next_idx(idx) = (idx == 5) ? 0 : idx+1.
- Sub-module rr_arb6:
  - Combinational priority scan.
  - Inputs: req[5:0], ptr[2:0]. Outputs: gnt_valid, gnt_idx[2:0].
  - The top level owns rr_ptr, the FSM, the lock and the output register.

## Test plan

- Reset/idle: assert reset mid-stream with in_valid = 6'b111111 → in the next cycle out_valid = 0, out_sel = 0. After release, the first grant is in1 (sel 000).
- Round-robin fairness: all six inputs hold single-flit packets (tail = 1), out_ready = 1 → out_sel sequence 0,1,2,3,4,5,0 on consecutive cycles, one flit per cycle.
- Packet lock:
  - Stimulus: in3 sends a 4-flit packet (tail on flit 4) while in1 and in5 are valid.
  - Required: four consecutive out_sel = 010 and only the last has out_tail = 1. in1 and in5 see in_ready = 0 throughout.
  - Next grant goes to in5 (ptr = 3 scans 3, 4 → in5 at index 4), not in1.
- Back-pressure: hold out_ready = 0 for 3 cycles with a flit held → out_data, out_tail and out_sel stable and all in_ready = 0. Releasing out_ready drains and loads in the same cycle with no bubble.
- Gap inside packet: in6 (index 5) sends a head flit, then drops in_valid for 2 cycles while in2 is valid → no flit from in2 until in6's tail transfers. rr_ptr wraps to 0 afterwards.
- Data integrity: random valids, tails, out_ready and payloads over 10k cycles → scoreboard keyed by out_sel matches per-input order. Packets are never interleaved, and no input with valid held is starved longer than 5 packets.
